// File: rtl/cache_pkg.sv
// Shared types for the write-back buffer: default widths, drain FSM states
// and the buffered {address, data} entry.
package cache_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wbb_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wbb_entry_t;

endpackage

// File: rtl/write_back_buffer_if.sv
// Cache-side, memory-side and lookup signals of the write-back buffer.
interface write_back_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_address;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_ready;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;

    logic [ADDR_WIDTH-1:0] lookup_address;
    logic                  lookup_hit;
    logic [DATA_WIDTH-1:0] lookup_data;

    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;

    modport master (
        output wb_valid, wb_address, wb_data, mem_ack, lookup_address,
        input  wb_ready, mem_req, mem_address, mem_wdata,
               lookup_hit, lookup_data, full, empty, count
    );

    modport slave (
        input  wb_valid, wb_address, wb_data, mem_ack, lookup_address,
        output wb_ready, mem_req, mem_address, mem_wdata,
               lookup_hit, lookup_data, full, empty, count
    );

endinterface

// File: rtl/write_back_buffer_cam.sv
// Parallel word-tag compare over the buffer; reports the youngest matching
// slot, walking from the head so later (younger) slots override earlier ones.
module write_back_buffer_cam #(
    parameter  int TAG_W = 30,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [DEPTH-1:0]            vld,
    input  logic [DEPTH-1:0]            excl,
    input  logic [PW-1:0]               head,
    input  logic [TAG_W-1:0]            key,
    output logic                        hit,
    output logic [PW-1:0]               idx
);

    logic [DEPTH-1:0] match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = vld[i] && !excl[i] && (tags[i] == key);
    end

    always_comb begin
        hit = 1'b0;
        idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[head + PW'(k)]) begin
                hit = 1'b1;
                idx = head + PW'(k);
            end
        end
    end

endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer: circular FIFO of evicted dirty words with coalescing,
// refill lookup and a two-state drain FSM toward main memory.
module write_back_buffer #(
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    write_back_buffer_if.slave bus
);
    import cache_pkg::wbb_state_t;
    import cache_pkg::IDLE;
    import cache_pkg::REQ;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ADDR_WIDTH - 2;

    wbb_state_t                       state_q, state_d;
    logic [DEPTH-1:0][TW-1:0]         tag_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0]                 vld_q;
    logic [PW-1:0]                    head_q, tail_q;
    logic [CW-1:0]                    count_q, count_d;

    logic             full_w, empty_w, ready_w;
    logic             in_flight, accept, push, coalesce, pop;
    logic [DEPTH-1:0] head_excl;
    logic             lu_hit, co_hit;
    logic [PW-1:0]    lu_idx, co_idx;
    logic             unused_lsbs;

    assign full_w    = (count_q == CW'(DEPTH));
    assign empty_w   = (count_q == '0);
    assign in_flight = (state_q == REQ);

    // Once presented to memory the head must not change, so it is hidden
    // from coalescing while a request is outstanding.
    assign head_excl = in_flight ? (DEPTH'(1) << head_q) : '0;

    write_back_buffer_cam #(.TAG_W(TW), .DEPTH(DEPTH)) u_cam_lookup (
        .tags (tag_q),
        .vld  (vld_q),
        .excl ('0),
        .head (head_q),
        .key  (bus.lookup_address[ADDR_WIDTH-1:2]),
        .hit  (lu_hit),
        .idx  (lu_idx)
    );

    write_back_buffer_cam #(.TAG_W(TW), .DEPTH(DEPTH)) u_cam_coalesce (
        .tags (tag_q),
        .vld  (vld_q),
        .excl (head_excl),
        .head (head_q),
        .key  (bus.wb_address[ADDR_WIDTH-1:2]),
        .hit  (co_hit),
        .idx  (co_idx)
    );

    assign ready_w  = !full_w || co_hit;
    assign accept   = bus.wb_valid && ready_w;
    assign coalesce = accept && co_hit;
    assign push     = accept && !co_hit;
    assign pop      = in_flight && bus.mem_ack;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty_w) state_d = REQ;
            REQ:     if (pop && (count_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            // push and pop never target the same slot: a push needs a free
            // slot, and a pop needs a non-empty buffer
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= bus.wb_address[ADDR_WIDTH-1:2];
            data_q[tail_q] <= bus.wb_data;
        end else if (coalesce) begin
            data_q[co_idx] <= bus.wb_data;
        end
    end

    assign bus.wb_ready    = ready_w;
    assign bus.mem_req     = in_flight;
    assign bus.mem_address = {tag_q[head_q], 2'b00};
    assign bus.mem_wdata   = data_q[head_q];
    assign bus.lookup_hit  = lu_hit;
    assign bus.lookup_data = lu_hit ? data_q[lu_idx] : '0;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.count       = count_q;

    // byte offsets never take part in matching
    assign unused_lsbs = ^{bus.wb_address[1:0], bus.lookup_address[1:0]};

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed bench for the write-back buffer: push, drain, coalesce, full
// back-pressure, in-flight head protection and asynchronous reset.
module tb_write_back_buffer;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    write_back_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) bus ();

    write_back_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bus.wb_valid   = 1'b1;
        bus.wb_address = a;
        bus.wb_data    = d;
        tick();
        bus.wb_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_address = '0; bus.wb_data = '0;
        bus.mem_ack = 1'b0; bus.lookup_address = 32'h100;
        tick(); tick();
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
        tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL rst_flags got empty=%b full=%b want 1/0", bus.empty, bus.full); end
        tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", bus.count); end
        tests++; if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 32'h0) begin fails++; $display("FAIL rst_lookup got hit=%b data=%h want 0/0", bus.lookup_hit, bus.lookup_data); end
        tests++; if (bus.wb_ready !== 1'b1) begin fails++; $display("FAIL rst_wb_ready got %b want 1", bus.wb_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.lookup_address = 32'h100;
        bus.mem_ack = 1'b1;  // ack while IDLE must be ignored
        push(32'h100, 32'hAAAA0001);
        bus.mem_ack = 1'b0;
        tests++; if (bus.count !== 3'd1 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL single_push got count=%0d req=%b want 1/0", bus.count, bus.mem_req); end
        tests++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 32'hAAAA0001) begin fails++; $display("FAIL single_lookup got hit=%b data=%h want 1/aaaa0001", bus.lookup_hit, bus.lookup_data); end
        tick();
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== 32'h100 || bus.mem_wdata !== 32'hAAAA0001) begin fails++; $display("FAIL single_req got req=%b a=%h d=%h want 1/100/aaaa0001", bus.mem_req, bus.mem_address, bus.mem_wdata); end
        tick();
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== 32'h100 || bus.mem_wdata !== 32'hAAAA0001) begin fails++; $display("FAIL single_stable got req=%b a=%h d=%h want 1/100/aaaa0001", bus.mem_req, bus.mem_address, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tests++; if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0 || bus.lookup_hit !== 1'b0) begin fails++; $display("FAIL single_done got empty=%b req=%b hit=%b want 1/0/0", bus.empty, bus.mem_req, bus.lookup_hit); end
    endtask

    task automatic test_full();
        wbb_entry_t exp_q [4];
        exp_q[0] = '{32'h100, 32'h1}; exp_q[1] = '{32'h104, 32'h2};
        exp_q[2] = '{32'h108, 32'h55}; exp_q[3] = '{32'h10C, 32'h4};
        push(32'h100, 32'h1); push(32'h104, 32'h2); push(32'h108, 32'h3); push(32'h10C, 32'h4);
        tests++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin fails++; $display("FAIL full_flag got full=%b count=%0d want 1/4", bus.full, bus.count); end
        bus.wb_address = 32'h110;
        #1;
        tests++; if (bus.wb_ready !== 1'b0) begin fails++; $display("FAIL full_ready_new got %b want 0", bus.wb_ready); end
        bus.wb_address = 32'h100;
        #1;
        tests++; if (bus.wb_ready !== 1'b0) begin fails++; $display("FAIL full_ready_head got %b want 0", bus.wb_ready); end
        bus.wb_address = 32'h108;
        #1;
        tests++; if (bus.wb_ready !== 1'b1) begin fails++; $display("FAIL full_ready_match got %b want 1", bus.wb_ready); end
        push(32'h108, 32'h55);
        bus.lookup_address = 32'h108;
        #1;
        tests++; if (bus.count !== 3'd4 || bus.lookup_data !== 32'h55) begin fails++; $display("FAIL full_coalesce got count=%0d data=%h want 4/55", bus.count, bus.lookup_data); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== exp_q[i].addr || bus.mem_wdata !== exp_q[i].data) begin fails++; $display("FAIL full_drain%0d got req=%b a=%h d=%h want 1/%h/%h", i, bus.mem_req, bus.mem_address, bus.mem_wdata, exp_q[i].addr, exp_q[i].data); end
            bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        tests++; if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL full_empty got empty=%b req=%b want 1/0", bus.empty, bus.mem_req); end
    endtask

    task automatic test_coalesce();
        wbb_entry_t exp_q [2];
        exp_q[0] = '{32'h200, 32'h1}; exp_q[1] = '{32'h204, 32'h3};
        push(32'h200, 32'h1); push(32'h204, 32'h2); push(32'h204, 32'h3);
        tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL coal_count got %0d want 2", bus.count); end
        for (int i = 0; i < 2; i++) begin
            tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== exp_q[i].addr || bus.mem_wdata !== exp_q[i].data) begin fails++; $display("FAIL coal_drain%0d got req=%b a=%h d=%h want 1/%h/%h", i, bus.mem_req, bus.mem_address, bus.mem_wdata, exp_q[i].addr, exp_q[i].data); end
            bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL coal_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_head_inflight();
        wbb_entry_t exp_q [2];
        exp_q[0] = '{32'h300, 32'h5}; exp_q[1] = '{32'h300, 32'h6};
        push(32'h300, 32'h5);
        tick();
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== 32'h300) begin fails++; $display("FAIL head_req got req=%b a=%h want 1/300", bus.mem_req, bus.mem_address); end
        push(32'h302, 32'h6);  // same word, different byte offset
        bus.lookup_address = 32'h300;
        #1;
        tests++; if (bus.count !== 3'd2 || bus.mem_wdata !== 32'h5) begin fails++; $display("FAIL head_stable got count=%0d d=%h want 2/5", bus.count, bus.mem_wdata); end
        tests++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 32'h6) begin fails++; $display("FAIL head_youngest got hit=%b data=%h want 1/6", bus.lookup_hit, bus.lookup_data); end
        bus.lookup_address = 32'h999;
        #1;
        tests++; if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 32'h0) begin fails++; $display("FAIL head_miss got hit=%b data=%h want 0/0", bus.lookup_hit, bus.lookup_data); end
        for (int i = 0; i < 2; i++) begin
            tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== exp_q[i].addr || bus.mem_wdata !== exp_q[i].data) begin fails++; $display("FAIL head_drain%0d got req=%b a=%h d=%h want 1/%h/%h", i, bus.mem_req, bus.mem_address, bus.mem_wdata, exp_q[i].addr, exp_q[i].data); end
            bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL head_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_full_push_ack();
        wbb_entry_t exp_q [3];
        exp_q[0] = '{32'h404, 32'h11}; exp_q[1] = '{32'h408, 32'h12}; exp_q[2] = '{32'h40C, 32'h13};
        push(32'h400, 32'h10); push(32'h404, 32'h11); push(32'h408, 32'h12); push(32'h40C, 32'h13);
        bus.wb_valid = 1'b1; bus.wb_address = 32'h500; bus.wb_data = 32'h77;
        bus.mem_ack = 1'b1;
        #1;
        tests++; if (bus.wb_ready !== 1'b0) begin fails++; $display("FAIL pa_ready got %b want 0", bus.wb_ready); end
        tick();
        bus.wb_valid = 1'b0; bus.mem_ack = 1'b0;
        bus.lookup_address = 32'h500;
        #1;
        tests++; if (bus.count !== 3'd3 || bus.lookup_hit !== 1'b0) begin fails++; $display("FAIL pa_count got count=%0d hit=%b want 3/0", bus.count, bus.lookup_hit); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== exp_q[i].addr || bus.mem_wdata !== exp_q[i].data) begin fails++; $display("FAIL pa_drain%0d got req=%b a=%h d=%h want 1/%h/%h", i, bus.mem_req, bus.mem_address, bus.mem_wdata, exp_q[i].addr, exp_q[i].data); end
            bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        tests++; if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL pa_empty got empty=%b req=%b want 1/0", bus.empty, bus.mem_req); end
    endtask

    task automatic test_async_reset();
        push(32'h600, 32'h7);
        tick();
        tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL ar_req got %b want 1", bus.mem_req); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin fails++; $display("FAIL ar_drop got req=%b count=%0d empty=%b want 0/0/1", bus.mem_req, bus.count, bus.empty); end
        bus.lookup_address = 32'h600;
        #1;
        tests++; if (bus.lookup_hit !== 1'b0) begin fails++; $display("FAIL ar_lookup got %b want 0", bus.lookup_hit); end
        tick();
        rst_n = 1'b1;
        push(32'h700, 32'h9);
        tick();
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_address !== 32'h700 || bus.mem_wdata !== 32'h9) begin fails++; $display("FAIL ar_restart got req=%b a=%h d=%h want 1/700/9", bus.mem_req, bus.mem_address, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tests++; if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL ar_empty got empty=%b req=%b want 1/0", bus.empty, bus.mem_req); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_coalesce();
        test_head_inflight();
        test_full_push_ack();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/write_back_buffer.md
WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of one cache word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of entries (power of two, at least 2).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port wb_valid  input  1  the cache presents an evicted dirty word.
REQ-007 The block SHALL have port wb_address  input  ADDR_WIDTH  the victim byte address.
REQ-008 The block SHALL have port wb_data  input  DATA_WIDTH  the victim data.
REQ-009 The block SHALL have port wb_ready  output  1  the buffer accepts the word this cycle.
REQ-010 The block SHALL have port mem_req  output  1  a main-memory write request.
REQ-011 The block SHALL have port mem_address  output  ADDR_WIDTH  the memory write address.
REQ-012 The block SHALL have port mem_wdata  output  DATA_WIDTH  the memory write data.
REQ-013 The block SHALL have port mem_ack  input  1  memory has completed the current write.
REQ-014 The block SHALL have port lookup_address  input  ADDR_WIDTH  the cache refill address to check.
REQ-015 The block SHALL have port lookup_hit  output  1  a buffered copy of lookup_address exists.
REQ-016 The block SHALL have port lookup_data  output  DATA_WIDTH  the buffered data, youngest match.
REQ-017 The block SHALL have ports full, empty (output, 1 each) and count (output, $clog2(DEPTH)+1), giving occupancy status.

Function
REQ-018 Circular FIFO SHALL store {address, data}; address matching SHALL use bits [ADDR_WIDTH-1:2] only.
REQ-019 Push SHALL occur on a rising edge with wb_valid && wb_ready.
REQ-020 Coalesce: if wb_address matches a valid entry that is not the in-flight head, that entry's data SHALL be overwritten, count unchanged.
REQ-021 Combinational wb_ready SHALL be !full || coalesce-match; it SHALL NOT depend on mem_ack (no pass-through when full).
REQ-022 Drain FSM SHALL have two states: IDLE → REQ when !empty (next edge); REQ → IDLE on mem_ack when the post-pop count is 0; otherwise it SHALL stay in REQ presenting the new head in the next cycle.
REQ-023 mem_req SHALL equal (state==REQ); mem_address SHALL be the head address with [1:0]=0; mem_wdata SHALL be the head data; both SHALL remain stable while mem_req && !mem_ack.
REQ-024 mem_ack SHALL be ignored in IDLE; the head entry SHALL pop on the edge where state==REQ && mem_ack.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 A coalesce targeting the in-flight head SHALL instead push a new entry (head data stays stable).
REQ-027 Lookup SHALL be combinational over all valid entries including the head; on multiple matches the youngest SHALL win; lookup_data SHALL be 0 when there is no hit.
REQ-028 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0); minimum push-to-mem_req latency SHALL be 1 cycle.

Reset
REQ-029 While rst_n is low: state IDLE, pointers 0, count 0, all valid bits 0, mem_req 0, empty 1, full 0, lookup_hit 0.
REQ-030 Reset asserted mid-request SHALL drop mem_req immediately and discard all entries; data storage SHALL NOT be reset.

Structure
REQ-031 Shared package cache_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, the wbb_state_t enum {IDLE, REQ} and the entry struct type.
REQ-032 A sub-module write_back_buffer_cam SHALL implement the parallel address compare and youngest-match priority, and SHALL serve both lookup and coalesce.

Verification
REQ-033 Push 0x100/0xAAAA0001, mem_ack 2 cycles after mem_req → mem_req is high the cycle after the push, the address and data are stable until ack, then empty=1.
REQ-034 Push four distinct addresses with mem_ack held low → full=1, wb_ready=0 for a fifth distinct address, and wb_ready=1 for a non-head match 0x108.
REQ-035 Push 0x200/0x1 then 0x204/0x2, then 0x204/0x3 → count=2 and the drained data for 0x204 is 0x3.
REQ-036 During the in-flight head 0x300/0x5, push 0x300/0x6 → count=2, the head writes 0x5, and a lookup of 0x300 returns 0x6.
REQ-037 When full, apply push+ack on the same edge → the push is refused, count=3, and the FSM stays in REQ presenting the next head.
REQ-038 Assert rst_n low asynchronously mid-REQ → mem_req falls before the next clk edge and count=0.
